// File: rtl/irq_timer.sv
// Periodic interrupt source: every HALF_PERIOD_US ticks raises a request carrying alternating RST 1 / RST 2 vectors.
// Optional overrun counter is enabled by defining IRQ_OVERRUN_COUNT_EN; otherwise o_overrun is tied to zero.
module irq_timer #(
  parameter int HALF_PERIOD_US = 8333
) (
  input  logic       i_clk_25MHz,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_int_enable,
  input  logic       i_int_ack,
  output logic       o_int,
  output logic [7:0] o_vector,
  output logic [7:0] o_overrun
);

  localparam logic [19:0] TERM     = 20'(HALF_PERIOD_US - 1);
  localparam logic [7:0]  VEC_RST1 = 8'hCF;
  localparam logic [7:0]  VEC_RST2 = 8'hD7;

  logic [19:0] r_count;
  logic        r_pending;
  logic        r_phase;
  logic        r_int;
  logic [7:0]  r_vector;

  logic w_terminal;
  logic w_ack;
  logic w_pending_nxt;

  assign w_terminal    = i_tick && (r_count == TERM);
  // An ack only counts while the CPU actually sees the request.
  assign w_ack         = i_int_ack && r_int;
  // A terminal tick re-arms pending even when the same cycle's ack consumes the old request.
  assign w_pending_nxt = w_terminal || (r_pending && !w_ack);

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset) begin
      r_count   <= '0;
      r_pending <= 1'b0;
      r_phase   <= 1'b0;
      r_int     <= 1'b0;
      r_vector  <= VEC_RST1;
    end else begin
      if (i_tick)
        r_count <= w_terminal ? 20'd0 : r_count + 20'd1;
      r_pending <= w_pending_nxt;
      r_int     <= w_pending_nxt && i_int_enable;
      if (w_terminal) begin
        r_vector <= r_phase ? VEC_RST2 : VEC_RST1;
        r_phase  <= ~r_phase;
      end
    end
  end

  assign o_int    = r_int;
  assign o_vector = r_vector;

`ifdef IRQ_OVERRUN_COUNT_EN
  logic [7:0] r_overrun;
  logic       w_overrun;

  assign w_overrun = w_terminal && r_pending && !w_ack;

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset)
      r_overrun <= '0;
    else if (w_overrun && (r_overrun != 8'hFF))
      r_overrun <= r_overrun + 8'd1;
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 8'h00;
`endif

endmodule

// File: tb/tb_irq_timer.sv
module tb_irq_timer;
  localparam int         HP  = 4;
  localparam logic [7:0] CF  = 8'hCF;
  localparam logic [7:0] D7  = 8'hD7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic       ack = 1'b0;
  logic       o_int;
  logic [7:0] o_vec;
  logic [7:0] o_ovr;

  irq_timer #(.HALF_PERIOD_US(HP)) dut (
    .i_clk_25MHz (clk),
    .i_reset     (rst_n),
    .i_tick      (tick),
    .i_int_enable(en),
    .i_int_ack   (ack),
    .o_int       (o_int),
    .o_vector    (o_vec),
    .o_overrun   (o_ovr)
  );

  always #20 clk = ~clk;

  typedef struct {
    int         due;
    logic       xint;
    logic [7:0] xvec;
    logic [7:0] xovr;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_edge = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) n_edge <= n_edge + 1;

  function automatic logic [7:0] ovr(input int n);
`ifdef IRQ_OVERRUN_COUNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  task automatic step(input logic t, input logic a);
    tick = t;
    ack  = a;
    @(posedge clk);
    #1;
    tick = 1'b0;
    ack  = 1'b0;
  endtask

  task automatic tick3();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic expect_out(input logic xi, input logic [7:0] xv, input logic [7:0] xo, input string nm);
    exp_t e;
    e.due  = n_edge;
    e.xint = xi;
    e.xvec = xv;
    e.xovr = xo;
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= n_edge) begin
        e = q.pop_front();
        n_cmp++;
        if (o_int !== e.xint || o_vec !== e.xvec || o_ovr !== e.xovr) begin
          n_bad++;
          $display("FAIL %s: got int=%b vec=%h ovr=%h, want int=%b vec=%h ovr=%h",
                   e.name, o_int, o_vec, o_ovr, e.xint, e.xvec, e.xovr);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] vecs [4];
    exp_t       e;
    vecs = '{CF, D7, CF, D7};

    rst_n = 1'b0;
    step(0, 0);
    step(0, 0);
    expect_out(0, CF, 8'h00, "reset");
    rst_n = 1'b1;
    en    = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick3(); tick3(); tick3();
      expect_out(0, (i == 0) ? CF : vecs[i-1], 8'h00, $sformatf("pre_term%0d", i));
      step(1, 0);
      expect_out(1, vecs[i], 8'h00, $sformatf("req_int%0d", i));
      step(0, 1);
      expect_out(0, vecs[i], 8'h00, $sformatf("req_ack%0d", i));
      step(0, 0);
    end

    en = 1'b0;
    tick3(); tick3(); tick3();
    step(1, 0);
    expect_out(0, CF, 8'h00, "dis_term");
    step(0, 0);
    step(0, 1);
    expect_out(0, CF, 8'h00, "dis_ack_ign");
    step(0, 0);
    expect_out(0, CF, 8'h00, "dis_hold");
    en = 1'b1;
    step(0, 0);
    expect_out(1, CF, 8'h00, "en_rise");
    step(0, 1);
    expect_out(0, CF, 8'h00, "en_ack");

    rst_n = 1'b0;
    step(0, 0);
    expect_out(0, CF, 8'h00, "rst_ovr");
    rst_n = 1'b1;
    step(0, 0);
    step(0, 0);
    for (int k = 1; k <= 300; k++) begin
      tick3(); tick3(); tick3();
      step(1, 0);
      if (k == 1 || k == 2 || k == 255 || k == 256 || k == 257 || k == 300)
        expect_out(1, (k % 2 == 1) ? CF : D7, ovr(k - 1), $sformatf("ovr_k%0d", k));
      step(0, 0);
      step(0, 0);
    end

    rst_n = 1'b0;
    step(0, 0);
    rst_n = 1'b1;
    step(0, 0);
    step(0, 0);
    tick3(); tick3(); tick3();
    step(1, 0);
    expect_out(1, CF, 8'h00, "co_req");
    step(0, 0);
    step(0, 0);
    tick3(); tick3(); tick3();
    step(1, 1);
    expect_out(1, D7, 8'h00, "co_term_ack");
    step(0, 0);
    expect_out(1, D7, 8'h00, "co_hold");
    n_cmp++;
    if (o_ovr !== 8'h00) begin
      n_bad++;
      $display("FAIL co_ovr_direct: got ovr=%h, want 00", o_ovr);
    end

    rst_n = 1'b0;
    step(1, 0);
    expect_out(0, CF, 8'h00, "rst_tick");
    n_cmp++;
    if (o_int !== 1'b0 || o_vec !== CF) begin
      n_bad++;
      $display("FAIL rst_tick_direct: got int=%b vec=%h, want int=0 vec=cf", o_int, o_vec);
    end
    rst_n = 1'b1;
    step(0, 0);
    step(0, 0);
    tick3(); tick3();
    step(1, 0);
    expect_out(0, CF, 8'h00, "rst_3ticks");
    step(0, 0);
    step(0, 0);
    step(1, 0);
    expect_out(1, CF, 8'h00, "rst_4ticks");
    n_cmp++;
    if (o_int !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_4ticks_direct: got int=%b, want 1", o_int);
    end

    repeat (3) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation never checked (due edge %0d, now %0d)", e.name, e.due, n_edge);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD_US, default 8333, giving the number of 1 us ticks between interrupt requests (half of a 60 Hz frame); legal range 2..2^20.
REQ-002 The block SHALL have port i_clk_25MHz, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port i_tick, input, 1 bit: one-cycle 1 us strobe from the tick generator.
REQ-005 The block SHALL have port i_int_enable, input, 1 bit: CPU interrupt-enable (INTE) flag.
REQ-006 The block SHALL have port i_int_ack, input, 1 bit: CPU interrupt acknowledge, level-sampled.
REQ-007 The block SHALL have port o_int, output, 1 bit: interrupt request to the CPU.
REQ-008 The block SHALL have port o_vector, output, 8 bits: RST opcode to jam on the data bus.
REQ-009 The block SHALL have port o_overrun, output, 8 bits: saturating count of lost requests (see Configuration).

Function
REQ-010 The block SHALL hold a 20-bit tick counter that increments only on cycles with i_tick=1 and ignores all cycles with i_tick=0.
REQ-011 The block SHALL, on i_tick=1 with counter=HALF_PERIOD_US-1, load the counter with 0 ("terminal tick"), set pending, load o_vector with the next vector and toggle the phase.
REQ-012 The block SHALL issue vectors in order 8'hCF (RST 1, mid-screen), 8'hD7 (RST 2, end-of-screen), 8'hCF, ... starting with 8'hCF after reset.
REQ-013 The block SHALL drive o_int as a register equal to pending AND i_int_enable, so o_int rises exactly 1 cycle after the terminal tick when enabled.
REQ-014 The block SHALL keep pending set while i_int_enable=0; o_int SHALL assert 1 cycle after i_int_enable rises.
REQ-015 The block SHALL clear pending when i_int_ack=1 in a cycle where o_int=1; o_int SHALL be 0 in the following cycle.
REQ-016 The block SHALL ignore i_int_ack when o_int=0.
REQ-017 The block SHALL keep o_vector constant while o_int=1, except on a terminal tick.
REQ-018 The block SHALL treat a terminal tick while pending is set and no ack occurs in that cycle as an overrun: pending stays set, o_vector takes the new vector, and the overrun counter increments.
REQ-019 The block SHALL treat a terminal tick in the same cycle as a valid ack as no overrun: the ack consumes the old request, pending stays set with the new vector, and o_int stays high.
REQ-020 The block SHALL wrap the counter with no gap: the tick after the terminal tick counts as 1.

Reset
REQ-021 The block SHALL, in any cycle with i_reset=0, set counter=0, pending=0, o_int=0, o_vector=8'hCF, phase=RST 1 and overrun counter=0, overriding all other inputs including a concurrent tick or ack.
REQ-022 The block SHALL, on reset asserted mid-request, drop o_int the next cycle and lose the pending request.

Configuration
REQ-023 The block SHALL, with macro IRQ_OVERRUN_COUNT_EN defined, implement o_overrun as an 8-bit counter that increments per REQ-018 and saturates at 8'hFF.
REQ-024 The block SHALL, with IRQ_OVERRUN_COUNT_EN undefined, keep the o_overrun port, tie it to 8'h00 and contain no counter logic.

Verification (HALF_PERIOD_US=4, i_tick every 3rd cycle)
REQ-025 The bench SHALL cover enabled request: i_int_enable=1, 4 ticks -> o_int=1 exactly 1 cycle after the 4th tick, o_vector=8'hCF; ack -> o_int=0 next cycle.
REQ-026 The bench SHALL cover alternation: 4 requests each acked -> vectors CF, D7, CF, D7.
REQ-027 The bench SHALL cover disabled hold: i_int_enable=0 across a terminal tick -> o_int stays 0; enable raised at cycle N -> o_int=1 at N+1 with o_vector=8'hCF.
REQ-028 The bench SHALL cover overrun: no ack for 2 terminal ticks -> o_vector=8'hD7, o_int stays 1, o_overrun=1 with the macro and 0 without it; 300 unacked periods -> o_overrun=8'hFF.
REQ-029 The bench SHALL cover ack coincident with a terminal tick: o_int stays 1, o_vector advances, o_overrun unchanged.
REQ-030 The bench SHALL cover reset while o_int=1 with a simultaneous tick: next cycle o_int=0, o_vector=8'hCF, counter restarts and the next request comes after a full 4 ticks.
